// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data memory with byte-lane writes and post-reset zero sweep
// Read-first, 1-cycle registered read; accesses are ignored until the clear sweep completes.
module data_mem_responder #(
  parameter int ADDR_W     = 14,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DM_OE,
  input  logic [3:0]        DM_WEB,
  input  logic [ADDR_W-1:0] DM_addr,
  input  logic [31:0]       DM_DI,
  output logic [31:0]       DM_DO,
  output logic              DM_ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_INIT, S_READY} state_t;

  localparam state_t RESET_STATE = INIT_CLEAR ? S_INIT : S_READY;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_clr_idx;
  logic              r_ready;
  logic [31:0]       r_do;
  logic [31:0]       r_mem [DEPTH];

  logic [3:0]        w_lane_we;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [31:0]       w_wr_data;
  logic              w_rd_en;
  logic              w_clr_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The sweep borrows the write port; core inputs only reach it in READY.
  always_comb begin
    w_state_next = r_state;
    w_lane_we    = 4'h0;
    w_wr_addr    = DM_addr;
    w_wr_data    = DM_DI;
    w_rd_en      = 1'b0;
    w_clr_inc    = 1'b0;
    case (r_state)
      S_INIT: begin
        w_lane_we = 4'hF;
        w_wr_addr = r_clr_idx;
        w_wr_data = 32'h0;
        w_clr_inc = 1'b1;
        if (&r_clr_idx) begin
          w_state_next = S_READY;
        end
      end
      S_READY: begin
        w_lane_we = ~DM_WEB;
        w_rd_en   = DM_OE;
      end
      default: w_state_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_idx <= '0;
      r_ready   <= 1'b0;
      r_do      <= 32'h0;
    end else begin
      if (w_clr_inc) begin
        r_clr_idx <= r_clr_idx + 1'b1;
      end
      r_ready <= (w_state_next == S_READY);
      if (w_rd_en) begin
        r_do <= r_mem[DM_addr];
      end
    end
  end

  // Array has no reset value; rst only blocks a write on the edge it coincides with.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lane_we[i]) begin
          r_mem[w_wr_addr][8*i +: 8] <= w_wr_data[8*i +: 8];
        end
      end
    end
  end

  assign DM_DO    = r_do;
  assign DM_ready = r_ready;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
// Uses ADDR_W=4 so the clear sweep lasts 16 cycles.
module tb_data_mem_responder;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              DM_OE = 1'b0;
  logic [3:0]        DM_WEB = 4'hF;
  logic [ADDR_W-1:0] DM_addr = '0;
  logic [31:0]       DM_DI = 32'h0;
  logic [31:0]       DM_DO;
  logic              DM_ready;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_responder #(.ADDR_W(ADDR_W), .INIT_CLEAR(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .DM_OE    (DM_OE),
    .DM_WEB   (DM_WEB),
    .DM_addr  (DM_addr),
    .DM_DI    (DM_DI),
    .DM_DO    (DM_DO),
    .DM_ready (DM_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] web);
    DM_OE   = 1'b0;
    DM_addr = a;
    DM_DI   = d;
    DM_WEB  = web;
    tick();
    DM_WEB  = 4'hF;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, output logic [31:0] d);
    DM_OE   = 1'b1;
    DM_WEB  = 4'hF;
    DM_addr = a;
    tick();
    d     = DM_DO;
    DM_OE = 1'b0;
  endtask

  // Counts cycles with DM_ready low, bounded; optionally drives an access for the first cycles.
  task automatic wait_sweep(input string tag, input bit poke, output int cycles);
    int  cnt;
    bit  do_nonzero;
    cnt = 0;
    do_nonzero = 1'b0;
    while (!DM_ready && cnt < 40) begin
      if (poke && cnt < 2) begin
        DM_OE   = 1'b1;
        DM_WEB  = 4'h0;
        DM_addr = 4'd2;
        DM_DI   = 32'hFFFF_FFFF;
      end else begin
        DM_OE  = 1'b0;
        DM_WEB = 4'hF;
      end
      tick();
      cnt++;
      if (!DM_ready && DM_DO !== 32'h0) do_nonzero = 1'b1;
    end
    DM_OE  = 1'b0;
    DM_WEB = 4'hF;
    cycles = cnt;
    check_eq({tag, "_init_cycles"}, 32'(cnt), 32'd16);
    check_eq({tag, "_do_zero_in_init"}, {31'b0, do_nonzero}, 32'h0);
  endtask

  initial begin
    logic [31:0] rdata;
    int          cyc;

    tick();
    tick();
    check_eq("rst_ready", {31'b0, DM_ready}, 32'h0);
    check_eq("rst_do", DM_DO, 32'h0);
    rst = 1'b0;

    wait_sweep("sweep1", 1'b1, cyc);
    check_eq("ready_after_sweep", {31'b0, DM_ready}, 32'h1);

    for (int a = 0; a < 16; a++) begin
      rd(ADDR_W'(a), rdata);
      check_eq($sformatf("clear_rd%0d", a), rdata, 32'h0);
    end

    wr(4'd3, 32'hDEAD_BEEF, 4'h0);
    rd(4'd3, rdata);
    check_eq("full_write", rdata, 32'hDEAD_BEEF);

    wr(4'd3, 32'h1122_3344, 4'b1010);
    rd(4'd3, rdata);
    check_eq("byte_lanes", rdata, 32'hDE22_BE44);

    wr(4'd3, 32'h0, 4'hF);
    rd(4'd3, rdata);
    check_eq("web_all_ones", rdata, 32'hDE22_BE44);

    DM_OE   = 1'b1;
    DM_WEB  = 4'h0;
    DM_addr = 4'd5;
    DM_DI   = 32'hA5A5_A5A5;
    tick();
    DM_WEB  = 4'hF;
    DM_OE   = 1'b0;
    check_eq("read_first_old", DM_DO, 32'h0);
    rd(4'd5, rdata);
    check_eq("read_first_new", rdata, 32'hA5A5_A5A5);

    wr(4'd7, 32'h0707_0707, 4'h0);
    wr(4'd8, 32'h0808_0808, 4'h0);
    DM_OE   = 1'b1;
    DM_addr = 4'd7;
    tick();
    check_eq("b2b_rd7", DM_DO, 32'h0707_0707);
    DM_addr = 4'd8;
    tick();
    check_eq("b2b_rd8", DM_DO, 32'h0808_0808);
    DM_OE   = 1'b0;

    rst = 1'b1;
    #1;
    check_eq("async_rst_do", DM_DO, 32'h0);
    check_eq("async_rst_ready", {31'b0, DM_ready}, 32'h0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check_eq("mid_sweep_ready", {31'b0, DM_ready}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_sweep("sweep2", 1'b0, cyc);

    rd(4'd3, rdata);
    check_eq("resweep_clears", rdata, 32'h0);

    wr(4'd4, 32'h1234_5678, 4'h0);
    wr(4'd9, 32'hCAFE_F00D, 4'h0);
    DM_OE   = 1'b1;
    DM_addr = 4'd4;
    tick();
    check_eq("oe_stream_1", DM_DO, 32'h1234_5678);
    DM_OE   = 1'b0;
    DM_addr = 4'd9;
    tick();
    check_eq("oe_stream_hold1", DM_DO, 32'h1234_5678);
    DM_OE   = 1'b1;
    tick();
    check_eq("oe_stream_2", DM_DO, 32'hCAFE_F00D);
    DM_OE   = 1'b0;
    DM_addr = 4'd4;
    tick();
    check_eq("oe_stream_hold2", DM_DO, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 14: word-address width; depth = 2**ADDR_W 32-bit words.
REQ-002 Parameter INIT_CLEAR, default 1: 1 = zero-sweep the array after reset; 0 = skip the sweep.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 DM_OE  input  1  read enable from the core's MEM stage.
REQ-006 DM_WEB  input  4  per-byte write enables, active-low; bit i controls DM_DI[8i+7:8i].
REQ-007 DM_addr  input  ADDR_W  word address.
REQ-008 DM_DI  input  32  write data.
REQ-009 DM_DO  output  32  registered read data.
REQ-010 DM_ready  output  1  high when the block accepts accesses.

Function
REQ-011 The block SHALL implement a two-state FSM: INIT and READY.
REQ-012 On leaving reset, the FSM SHALL be in INIT when INIT_CLEAR=1, and in READY when INIT_CLEAR=0.
REQ-013 In INIT, the block SHALL write 32'h0 to word clr_idx on each cycle, and clr_idx SHALL increment from 0.
- clr_idx is an ADDR_W-bit counter.
- When clr_idx reaches 2**ADDR_W-1, that word is cleared and the FSM moves to READY on the same edge.
- The sweep takes exactly 2**ADDR_W cycles.
REQ-014 DM_ready SHALL be 1 in READY and 0 in INIT; it is a registered output with no combinational path from the inputs.
REQ-015 In INIT, the block SHALL ignore DM_OE, DM_WEB, DM_addr and DM_DI, and DM_DO SHALL hold 32'h0.
REQ-016 Write (READY only): on a rising edge, for each byte lane i with DM_WEB[i]=0, the block SHALL update mem[DM_addr] byte i from DM_DI; lanes with DM_WEB[i]=1 are unchanged.
REQ-017 DM_WEB=4'hF SHALL cause no write.
REQ-018 Read (READY only): when DM_OE=1 at a rising edge, DM_DO SHALL show mem[DM_addr] after that edge (latency 1 cycle).
REQ-019 When DM_OE=0, DM_DO SHALL hold its previous value.
REQ-020 Simultaneous read and write to the same address in one cycle SHALL be read-first: DM_DO returns the pre-write word, and the write still takes effect.
REQ-021 Back-to-back accesses SHALL be supported every cycle with no bubbles; throughput is 1 access per cycle.
REQ-022 DM_addr SHALL address words only; out-of-range addresses cannot occur because the address width equals ADDR_W.
REQ-023 Array contents SHALL NOT be asynchronously reset; only the INIT sweep clears them.

Reset
REQ-024 While rst=1, the block SHALL hold:
- DM_DO=32'h0
- DM_ready=0
- clr_idx=0
- FSM in INIT (INIT_CLEAR=1) or READY (INIT_CLEAR=0); with INIT_CLEAR=0, DM_ready goes high on the first edge after rst falls.
REQ-025 Reset asserted mid-sweep or mid-access SHALL abort immediately.
- With INIT_CLEAR=1, the sweep restarts from clr_idx=0 after release.
- A write in flight on the edge coincident with rst assertion SHALL NOT be committed.

Verification (bench uses ADDR_W=4)
REQ-026 Reset release, INIT_CLEAR=1 -> DM_ready=0 for 16 cycles, then 1; reading every address 0..15 returns 32'h0.
REQ-027 Write addr 3, DI=32'hDEADBEEF, WEB=4'h0; next cycle OE=1 addr 3 -> DM_DO=32'hDEADBEEF one cycle after the read edge.
REQ-028 Starting from mem[3]=32'hDEADBEEF: write addr 3, DI=32'h11223344, WEB=4'b1010; then read addr 3 -> DM_DO=32'hDE22BE44.
REQ-029 Same cycle: OE=1, WEB=4'h0, addr 5, DI=32'hA5A5A5A5, with mem[5]=0 -> DM_DO=32'h0; a read on the next cycle returns 32'hA5A5A5A5.
REQ-030 Access attempted during INIT (write addr 2 at sweep cycle 1) -> no effect; after READY, addr 2 reads 32'h0 and DM_DO stayed 0 throughout INIT.
REQ-031 rst pulsed at sweep cycle 7 -> DM_ready stays 0 for a full 16 cycles after release; a read stream with OE toggling afterwards shows DM_DO holding whenever OE=0.
